control_multi: RTL and testbench
================================

Name: control_multi

Overview:
- Multi-cycle main controller: a Moore FSM that sequences the shared datapath (PC, IR, register file, one ALU, one unified memory) over several clocks per instruction.
- Replaces control_single when the datapath is folded into mips_multi.
- Adds a memory-ready handshake with a wait-state watchdog, so the memory may take a variable number of cycles.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive cycles with mem_ready=0 in a memory state before abort. Legal range 1..255.
- TMR_W, 8: width of the wait counter. Must satisfy 2^TMR_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the IR
- mem_ready  in  1  memory has completed the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero (beq)
- IorD  out  1  0=PC, 1=ALUOut drives the memory address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  1=MDR, 0=ALUOut to the register-file write data
- RegDst  out  1  1=rd, 0=rt
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  0=PC, 1=A register
- ALUSrcB  out  2  00=B, 01=4, 10=sign-extended immediate, 11=sign-extended immediate<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct-decoded (to alu_ctl)
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump address
- state  out  4  current state, for debug
- instr_done  out  1  one-cycle pulse on the last cycle of each retired instruction
- mem_err  out  1  one-cycle pulse on watchdog abort
- illegal_op  out  1  one-cycle pulse in DECODE on an unknown opcode

Behaviour:
- States (4-bit encoding): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQ=8, JMP=9, IEX=10, IWB=11.
- Reset: rst=1 at a clock edge sets state to FETCH and the wait counter to 0.
  - While rst=1, all write enables and pulses are forced to 0: PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, instr_done, mem_err, illegal_op.
  - All other outputs are 0 during reset.
- Outputs not listed for a state are 0.

Per-state outputs and transitions:
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = mem_ready (Mealy-gated).
  - mem_ready=1 -> DECODE. Otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target into ALUOut). Next state by opcode:
  - 0x00 -> REX
  - 0x23 (lw) or 0x2B (sw) -> MEMADR
  - 0x04 (beq) -> BEQ
  - 0x02 (j) -> JMP
  - 0x08 (addi) -> IEX
  - anything else: illegal_op=1, -> FETCH, no instr_done.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. mem_ready=1 -> MEMWB. Otherwise stay.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1 -> FETCH.
- MEMWR: MemWrite=1, IorD=1. mem_ready=1 -> instr_done=1, -> FETCH. Otherwise stay.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1 -> FETCH.
- JMP: PCWrite=1, PCSource=10, instr_done=1 -> FETCH.
- IEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.

Opcode handling:
- opcode is sampled only in DECODE and MEMADR. The IR is stable there because IRWrite=0 outside FETCH.

Latency with mem_ready held at 1:
- R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Watchdog:
- The counter increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0, and clears on any state change.
- When the counter reaches MEM_TIMEOUT-1 and mem_ready is still 0, that cycle asserts mem_err=1 and the next state is FETCH.
- An abort writes nothing: no IRWrite, PCWrite or RegWrite, and the instruction is not retired. A FETCH abort simply re-fetches the same PC.
- mem_ready=1 on the timeout cycle wins: normal completion, no mem_err.

Reset in mid-instruction:
- The next edge goes to FETCH, with all enables low during reset. Any partially executed instruction is discarded.

Decomposition:
- Package mips_multi_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp, ALUSrcB and PCSource codes
- One sub-module, mem_wait_timer: clk, rst, clr, inc, expired; parameterised by MEM_TIMEOUT and TMR_W.

Test Plan:
- R-type: opcode=0x00, mem_ready=1 -> states 0,1,6,7. RegWrite=1 and RegDst=1 only in cycle 4. instr_done on cycle 4. IRWrite=PCWrite=1 on cycle 1.
- lw: opcode=0x23, mem_ready low for 2 cycles in MEMRD -> MEMRD held for 3 cycles, MemRead=IorD=1 throughout, then MEMWB with MemtoReg=1 and RegWrite=1. Total 7 cycles.
- beq, then j: states 0,1,8 with PCWriteCond=1 and PCSource=01; then 0,1,9 with PCWrite=1 and PCSource=10. 3 cycles each.
- Illegal opcode 0x3F -> illegal_op pulses in DECODE, next state FETCH, no RegWrite, MemWrite or instr_done.
- Watchdog, MEM_TIMEOUT=4: sw with mem_ready=0 forever -> MemWrite=1 for 4 cycles, mem_err on the 4th, then FETCH. Repeat with mem_ready=1 on the 4th cycle -> no mem_err, instr_done=1.
- Reset mid-MEMWR: assert rst for 1 cycle -> all enables 0 during rst, state=0 after the edge. The next instruction then executes normally.

Source files
------------

// File: rtl/mips_multi_pkg.sv
// Shared definitions for the multi-cycle MIPS controller and its helpers:
// state encodings, opcodes and the datapath mux/ALU select codes.
package mips_multi_pkg;

  // Controller states; the numeric values appear on the debug state port
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JMP    = 4'd9,
    S_IEX    = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  // Primary opcodes (instr[31:26]) understood by the controller
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // ALUOp codes handed to alu_ctl
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the memory handshake and are covered by the watchdog
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/control_multi_mem_wait_timer.sv
// Wait-state watchdog: counts consecutive stalled memory cycles and flags
// the cycle on which the stall budget is used up.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(MEM_TIMEOUT - 1);

  logic [TMR_W-1:0] count;

  // Count stalled cycles; clearing takes priority so an abort or a state
  // change always starts the next wait from zero, and the count never
  // runs past the expiry value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/control_multi.sv
// Multi-cycle main controller: Moore FSM sequencing the shared MIPS datapath
// over several clocks per instruction, with a memory-ready handshake and a
// watchdog that aborts a stalled memory access.
module control_multi
  import mips_multi_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       mem_err,
  output logic       illegal_op
);

  state_t state_q;
  state_t state_d;
  logic   waiting;
  logic   expired;
  logic   abort;
  logic   tmr_clr;

  // A stall is a memory state without mem_ready; a stall on the last
  // allowed cycle is an abort. A ready on that cycle still completes.
  assign waiting = is_mem_state(state_q) && !mem_ready;
  assign abort   = waiting && expired;
  assign tmr_clr = abort || (state_d != state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMR_W       (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (waiting),
    .expired (expired)
  );

  // State register; reset always returns to FETCH, discarding any
  // partially executed instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; every output defaults low and the whole
  // set is forced low while reset is held.
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    instr_done  = 1'b0;
    mem_err     = 1'b0;
    illegal_op  = 1'b0;
    state       = state_q;

    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
        mem_err  = abort;
        if (mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH2;
        case (opcode)
          OP_RTYPE:     state_d = S_REX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
          OP_ADDI:      state_d = S_IEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        mem_err = abort;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (abort) begin
          state_d = S_FETCH;
        end
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        mem_err    = abort;
        if (mem_ready || abort) begin
          state_d = S_FETCH;
        end
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_B;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      instr_done  = 1'b0;
      mem_err     = 1'b0;
      illegal_op  = 1'b0;
      state       = 4'd0;
    end
  end

endmodule

// File: tb/tb_control_multi.sv
// Self-checking bench for control_multi: a per-cycle vector table plus
// hand-written watchdog and reset sequences, all checked via a scoreboard.
module tb_control_multi;

  // Control word layout:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA}, ALUSrcB, ALUOp, PCSource, {instr_done,mem_err,illegal_op}
  localparam logic [18:0] C_RESET   = 19'b0000000000_00_00_00_000;
  localparam logic [18:0] C_F_WAIT  = 19'b0001000000_01_00_00_000;
  localparam logic [18:0] C_F_GO    = 19'b1001010000_01_00_00_000;
  localparam logic [18:0] C_F_ABT   = 19'b0001000000_01_00_00_010;
  localparam logic [18:0] C_DEC     = 19'b0000000000_11_00_00_000;
  localparam logic [18:0] C_DEC_ILL = 19'b0000000000_11_00_00_001;
  localparam logic [18:0] C_MEMADR  = 19'b0000000001_10_00_00_000;
  localparam logic [18:0] C_MEMRD   = 19'b0011000000_00_00_00_000;
  localparam logic [18:0] C_MEMWB   = 19'b0000001010_00_00_00_100;
  localparam logic [18:0] C_WR_WAIT = 19'b0010100000_00_00_00_000;
  localparam logic [18:0] C_WR_GO   = 19'b0010100000_00_00_00_100;
  localparam logic [18:0] C_WR_ABT  = 19'b0010100000_00_00_00_010;
  localparam logic [18:0] C_REX     = 19'b0000000001_00_10_00_000;
  localparam logic [18:0] C_RWB     = 19'b0000000110_00_00_00_100;
  localparam logic [18:0] C_BEQ     = 19'b0100000001_00_01_01_100;
  localparam logic [18:0] C_JMP     = 19'b1000000000_00_00_10_100;
  localparam logic [18:0] C_IEX     = 19'b0000000001_10_00_00_000;
  localparam logic [18:0] C_IWB     = 19'b0000000010_00_00_00_100;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [18:0] ctrl;
  } vec_t;

  typedef struct {
    int          tag;
    logic [3:0]  st;
    logic [18:0] ctrl;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, mem_err, illegal_op;
  logic [18:0] actCtrl;

  vec_t vecs[$];
  exp_t sb[$];
  int   testsRun;
  int   testsFailed;

  control_multi #(
    .MEM_TIMEOUT (4),
    .TMR_W       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .state       (state),
    .instr_done  (instr_done),
    .mem_err     (mem_err),
    .illegal_op  (illegal_op)
  );

  assign actCtrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                    PCSource, instr_done, mem_err, illegal_op};

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, record what the DUT should show this cycle,
  // then advance past the next rising edge
  task automatic applyStimulus(input int tag, input logic r, input logic [5:0] op,
                               input logic mr, input logic [3:0] st,
                               input logic [18:0] ctrl);
    exp_t e;
    rst       = r;
    opcode    = op;
    mem_ready = mr;
    e.tag  = tag;
    e.st   = st;
    e.ctrl = ctrl;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare it with the settled DUT outputs
  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    testsRun++;
    if (state !== e.st) begin
      testsFailed++;
      $display("[TB] FAIL step%0d state: got %0d expected %0d", e.tag, state, e.st);
    end
    testsRun++;
    if (actCtrl !== e.ctrl) begin
      testsFailed++;
      $display("[TB] FAIL step%0d ctrl: got %b expected %b", e.tag, actCtrl, e.ctrl);
    end
  endtask

  // Compare on the falling edge, away from the state update
  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput();
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst       = 1'b1;
    opcode    = 6'h00;
    mem_ready = 1'b0;

    // Reset, then R-type, lw with two stalls, beq, j, addi, illegal, sw
    vecs.push_back('{1'b1, 6'h00, 1'b1, 4'd0, C_RESET});
    vecs.push_back('{1'b1, 6'h00, 1'b0, 4'd0, C_RESET});
    vecs.push_back('{1'b0, 6'h00, 1'b1, 4'd0, C_F_GO});
    vecs.push_back('{1'b0, 6'h00, 1'b1, 4'd1, C_DEC});
    vecs.push_back('{1'b0, 6'h00, 1'b1, 4'd6, C_REX});
    vecs.push_back('{1'b0, 6'h00, 1'b1, 4'd7, C_RWB});
    vecs.push_back('{1'b0, 6'h23, 1'b1, 4'd0, C_F_GO});
    vecs.push_back('{1'b0, 6'h23, 1'b1, 4'd1, C_DEC});
    vecs.push_back('{1'b0, 6'h23, 1'b1, 4'd2, C_MEMADR});
    vecs.push_back('{1'b0, 6'h23, 1'b0, 4'd3, C_MEMRD});
    vecs.push_back('{1'b0, 6'h23, 1'b0, 4'd3, C_MEMRD});
    vecs.push_back('{1'b0, 6'h23, 1'b1, 4'd3, C_MEMRD});
    vecs.push_back('{1'b0, 6'h23, 1'b1, 4'd4, C_MEMWB});
    vecs.push_back('{1'b0, 6'h04, 1'b1, 4'd0, C_F_GO});
    vecs.push_back('{1'b0, 6'h04, 1'b1, 4'd1, C_DEC});
    vecs.push_back('{1'b0, 6'h04, 1'b1, 4'd8, C_BEQ});
    vecs.push_back('{1'b0, 6'h02, 1'b1, 4'd0, C_F_GO});
    vecs.push_back('{1'b0, 6'h02, 1'b1, 4'd1, C_DEC});
    vecs.push_back('{1'b0, 6'h02, 1'b1, 4'd9, C_JMP});
    vecs.push_back('{1'b0, 6'h08, 1'b1, 4'd0, C_F_GO});
    vecs.push_back('{1'b0, 6'h08, 1'b1, 4'd1, C_DEC});
    vecs.push_back('{1'b0, 6'h08, 1'b1, 4'd10, C_IEX});
    vecs.push_back('{1'b0, 6'h08, 1'b1, 4'd11, C_IWB});
    vecs.push_back('{1'b0, 6'h3F, 1'b1, 4'd0, C_F_GO});
    vecs.push_back('{1'b0, 6'h3F, 1'b1, 4'd1, C_DEC_ILL});
    vecs.push_back('{1'b0, 6'h2B, 1'b0, 4'd0, C_F_WAIT});
    vecs.push_back('{1'b0, 6'h2B, 1'b1, 4'd0, C_F_GO});
    vecs.push_back('{1'b0, 6'h2B, 1'b1, 4'd1, C_DEC});
    vecs.push_back('{1'b0, 6'h2B, 1'b1, 4'd2, C_MEMADR});
    vecs.push_back('{1'b0, 6'h2B, 1'b1, 4'd5, C_WR_GO});

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      applyStimulus(i, vecs[i].rst, vecs[i].op, vecs[i].mr, vecs[i].st, vecs[i].ctrl);
    end

    // sw that never gets mem_ready: four MemWrite cycles, abort on the 4th
    applyStimulus(100, 1'b0, 6'h2B, 1'b1, 4'd0, C_F_GO);
    applyStimulus(101, 1'b0, 6'h2B, 1'b1, 4'd1, C_DEC);
    applyStimulus(102, 1'b0, 6'h2B, 1'b1, 4'd2, C_MEMADR);
    for (int k = 0; k < 3; k++) applyStimulus(103 + k, 1'b0, 6'h2B, 1'b0, 4'd5, C_WR_WAIT);
    applyStimulus(106, 1'b0, 6'h2B, 1'b0, 4'd5, C_WR_ABT);

    // Same sw, but ready arrives on the timeout cycle: normal completion
    applyStimulus(110, 1'b0, 6'h2B, 1'b1, 4'd0, C_F_GO);
    applyStimulus(111, 1'b0, 6'h2B, 1'b1, 4'd1, C_DEC);
    applyStimulus(112, 1'b0, 6'h2B, 1'b1, 4'd2, C_MEMADR);
    for (int k = 0; k < 3; k++) applyStimulus(113 + k, 1'b0, 6'h2B, 1'b0, 4'd5, C_WR_WAIT);
    applyStimulus(116, 1'b0, 6'h2B, 1'b1, 4'd5, C_WR_GO);

    // FETCH abort re-fetches, and the stall count restarts from zero
    for (int k = 0; k < 3; k++) applyStimulus(120 + k, 1'b0, 6'h02, 1'b0, 4'd0, C_F_WAIT);
    applyStimulus(123, 1'b0, 6'h02, 1'b0, 4'd0, C_F_ABT);
    for (int k = 0; k < 3; k++) applyStimulus(124 + k, 1'b0, 6'h02, 1'b0, 4'd0, C_F_WAIT);
    applyStimulus(127, 1'b0, 6'h02, 1'b1, 4'd0, C_F_GO);
    applyStimulus(128, 1'b0, 6'h02, 1'b1, 4'd1, C_DEC);
    applyStimulus(129, 1'b0, 6'h02, 1'b1, 4'd9, C_JMP);

    // Reset in the middle of a stalled sw, then a clean R-type
    applyStimulus(130, 1'b0, 6'h2B, 1'b1, 4'd0, C_F_GO);
    applyStimulus(131, 1'b0, 6'h2B, 1'b1, 4'd1, C_DEC);
    applyStimulus(132, 1'b0, 6'h2B, 1'b1, 4'd2, C_MEMADR);
    applyStimulus(133, 1'b0, 6'h2B, 1'b0, 4'd5, C_WR_WAIT);
    applyStimulus(134, 1'b1, 6'h2B, 1'b1, 4'd0, C_RESET);
    for (int k = 0; k < 3; k++) applyStimulus(135 + k, 1'b0, 6'h00, 1'b0, 4'd0, C_F_WAIT);
    applyStimulus(138, 1'b0, 6'h00, 1'b1, 4'd0, C_F_GO);
    applyStimulus(139, 1'b0, 6'h00, 1'b1, 4'd1, C_DEC);
    applyStimulus(140, 1'b0, 6'h00, 1'b1, 4'd6, C_REX);
    applyStimulus(141, 1'b0, 6'h00, 1'b1, 4'd7, C_RWB);

    // Every pushed expectation must have been consumed by the checker
    testsRun++;
    if (sb.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
